// File: rtl/pe_stream_arbiter.sv
// pe_stream_arbiter: 2:1 packet merger of two 64-bit PE streams onto one router link.
// Ports: CLK, SYS_RST_N (async, active-low); D0/D1 + D0_VALID/D1_VALID flit inputs;
// D0_BP/D1_BP registered occupancy backpressure; Q/Q_VALID merged output, Q_BP downstream stall;
// GRANT one-hot packet owner (00 idle); ERR_OVF sticky per-input overflow.
module pe_stream_arbiter #(
  parameter int FIFO_DEPTH = 16,
  parameter int BP_SLACK   = 4,
  parameter int LEN_W      = 16
) (
  input  logic        CLK,
  input  logic        SYS_RST_N,
  input  logic [63:0] D0,
  input  logic        D0_VALID,
  output logic        D0_BP,
  input  logic [63:0] D1,
  input  logic        D1_VALID,
  output logic        D1_BP,
  output logic [63:0] Q,
  output logic        Q_VALID,
  input  logic        Q_BP,
  output logic [1:0]  GRANT,
  output logic [1:0]  ERR_OVF
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] BP_TH = (AW+1)'(FIFO_DEPTH - BP_SLACK);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [63:0] mem_q [2][FIFO_DEPTH];
  logic [63:0] din [2];
  logic [AW-1:0] wp_q [2], wp_d [2], rp_q [2], rp_d [2];
  logic [AW:0] cnt_q [2], cnt_d [2];
  logic [1:0] wv, wr, pop, ne, full, bp_q, bp_d, ovf_q, ovf_d, grant_q, grant_d;
  logic last_q, last_d, first_q, first_d, qv_q, qv_d, g, done;
  logic [LEN_W:0] rem_q, rem_d;
  logic [63:0] q_q, q_d, head;
  assign din[0] = D0;
  assign din[1] = D1;
  assign wv = {D1_VALID, D0_VALID};
  assign g = grant_q[1];
  assign head = mem_q[g][rp_q[g]];
  assign done = first_q ? head[LEN_W-1:0] == '0 : rem_q == (LEN_W+1)'(1);
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ne[i] = cnt_q[i] != '0;
      full[i] = cnt_q[i] == FULL;
      pop[i] = state_q == SEND && grant_q[i] && ne[i] && !Q_BP;
      // a pop frees the slot on the same edge, so a full FIFO still accepts
      wr[i] = wv[i] && (!full[i] || pop[i]);
      wp_d[i] = wp_q[i] + AW'(wr[i]);
      rp_d[i] = rp_q[i] + AW'(pop[i]);
      cnt_d[i] = cnt_q[i] + (AW+1)'(wr[i]) - (AW+1)'(pop[i]);
      ovf_d[i] = ovf_q[i] | (wv[i] & ~wr[i]);
      bp_d[i] = cnt_d[i] >= BP_TH;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    first_d = first_q;
    rem_d = rem_q;
    q_d = q_q;
    qv_d = |pop;
    if (state_q == IDLE && |ne) begin
      state_d = SEND;
      first_d = 1'b1;
      grant_d = &ne ? (last_q ? 2'b01 : 2'b10) : ne;
    end
    if (|pop) begin
      q_d = head;
      first_d = 1'b0;
      rem_d = first_q ? {1'b0, head[LEN_W-1:0]} : rem_q - (LEN_W+1)'(1);
      if (done) begin
        state_d = IDLE;
        grant_d = '0;
        last_d = g;
      end
    end
  end
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 2; i++)
      if (wr[i]) mem_q[i][wp_q[i]] <= din[i];
  end
  always_ff @(posedge CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      for (int i = 0; i < 2; i++) begin
        wp_q[i] <= '0;
        rp_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      bp_q <= '0;
      ovf_q <= '0;
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= 1'b1;
      first_q <= 1'b1;
      rem_q <= '0;
      q_q <= '0;
      qv_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wp_q[i] <= wp_d[i];
        rp_q[i] <= rp_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      bp_q <= bp_d;
      ovf_q <= ovf_d;
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      first_q <= first_d;
      rem_q <= rem_d;
      q_q <= q_d;
      qv_q <= qv_d;
    end
  end
  assign D0_BP = bp_q[0];
  assign D1_BP = bp_q[1];
  assign Q = q_q;
  assign Q_VALID = qv_q;
  assign GRANT = grant_q;
  assign ERR_OVF = ovf_q;
endmodule

// File: tb/tb_pe_stream_arbiter.sv
// tb_pe_stream_arbiter: directed and randomized scoreboard bench for pe_stream_arbiter.
module tb_pe_stream_arbiter;
  localparam int LEN_W = 16;
  logic CLK = 1'b0, SYS_RST_N = 1'b0;
  logic [63:0] D0 = '0, D1 = '0;
  logic D0_VALID = 1'b0, D1_VALID = 1'b0, Q_BP = 1'b0;
  logic D0_BP, D1_BP, Q_VALID;
  logic [63:0] Q;
  logic [1:0] GRANT, ERR_OVF;
  pe_stream_arbiter #(.FIFO_DEPTH(16), .BP_SLACK(4), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .SYS_RST_N(SYS_RST_N),
    .D0(D0), .D0_VALID(D0_VALID), .D0_BP(D0_BP),
    .D1(D1), .D1_VALID(D1_VALID), .D1_BP(D1_BP),
    .Q(Q), .Q_VALID(Q_VALID), .Q_BP(Q_BP),
    .GRANT(GRANT), .ERR_OVF(ERR_OVF)
  );
  always #5 CLK = ~CLK;
  int cyc_n = 0;
  always @(posedge CLK) cyc_n <= cyc_n + 1;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] exp0[$], exp1[$];
  int src_q[$];
  int vt[$];
  logic [1:0] gt[$];
  bit in_pkt = 1'b0;
  int mrem = 0, cur = 0;
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endfunction
  function automatic logic [63:0] hdr(int s, int sq, int n);
    return {s[0], sq[14:0], 32'h0, n[15:0]};
  endfunction
  function automatic logic [63:0] pl(int s, int sq, logic [31:0] d);
    return {s[0], sq[14:0], 16'hBEEF, d};
  endfunction
  always @(negedge CLK) begin
    if (!SYS_RST_N) begin
      in_pkt = 1'b0;
      mrem = 0;
    end else if (Q_VALID) begin
      vt.push_back(cyc_n);
      gt.push_back(GRANT);
      if (!in_pkt) begin
        cur = int'(Q[63]);
        mrem = int'(Q[LEN_W-1:0]);
        in_pkt = mrem != 0;
        if (src_q.size() != 0) chk("pkt_order", 64'(Q[63]), 64'(src_q.pop_front()));
      end else begin
        mrem--;
        in_pkt = mrem != 0;
      end
      if ((cur == 0) ? exp0.size() == 0 : exp1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_flit: got %h while no flit is owed on input %0d", Q, cur);
      end else if (cur == 0) chk("flit_in0", Q, exp0.pop_front());
      else chk("flit_in1", Q, exp1.pop_front());
    end
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic drive(bit v0, logic [63:0] f0, bit v1, logic [63:0] f1);
    D0_VALID = v0; D0 = f0; D1_VALID = v1; D1 = f1;
    if (v0) exp0.push_back(f0);
    if (v1) exp1.push_back(f1);
    tick();
  endtask
  task automatic do_reset();
    SYS_RST_N = 1'b0;
    D0_VALID = 1'b0; D1_VALID = 1'b0; Q_BP = 1'b0;
    exp0.delete(); exp1.delete(); src_q.delete();
    repeat (2) tick();
    SYS_RST_N = 1'b1;
    tick();
  endtask
  task automatic drain(int budget);
    int k;
    k = 0;
    D0_VALID = 1'b0; D1_VALID = 1'b0;
    while ((exp0.size() + exp1.size()) != 0 && k < budget) begin
      tick();
      k++;
    end
    chk("drain_left", 64'(exp0.size() + exp1.size()), 64'd0);
    repeat (3) tick();
  endtask
  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t0, n;
    bit fin;
    bit v[2];
    logic [63:0] f[2];
    int rg[2], sq[2];
    // reset state
    #2;
    chk("rst_qvalid", 64'(Q_VALID), 64'd0);
    chk("rst_q", Q, 64'd0);
    chk("rst_grant", 64'(GRANT), 64'd0);
    chk("rst_bp", 64'({D1_BP, D0_BP}), 64'd0);
    chk("rst_ovf", 64'(ERR_OVF), 64'd0);
    // single packet latency and grant
    do_reset();
    vt.delete(); gt.delete();
    t0 = cyc_n;
    drive(1, hdr(0, 1, 3), 0, '0);
    for (int k = 1; k < 4; k++) drive(1, pl(0, 1, 32'hA0 + 32'(k)), 0, '0);
    drain(50);
    chk("t1_count", 64'(vt.size()), 64'd4);
    if (vt.size() == 4)
      for (int k = 0; k < 4; k++) begin
        chk("t1_time", 64'(vt[k]), 64'(t0 + 3 + k));
        chk("t1_grant", 64'(gt[k]), (k < 3) ? 64'd1 : 64'd0);
      end
    // both inputs backlogged: alternation and one idle cycle between packets
    do_reset();
    vt.delete(); gt.delete();
    src_q = '{0, 1, 0, 1};
    drive(1, hdr(0, 2, 1), 1, hdr(1, 2, 1));
    drive(1, pl(0, 2, 32'h11), 1, pl(1, 2, 32'h21));
    drive(1, hdr(0, 3, 1), 1, hdr(1, 3, 1));
    drive(1, pl(0, 3, 32'h12), 1, pl(1, 3, 32'h22));
    drain(60);
    chk("t2_count", 64'(vt.size()), 64'd8);
    if (vt.size() == 8)
      for (int k = 1; k < 8; k++) chk("t2_gap", 64'(vt[k] - vt[k-1]), (k % 2 == 1) ? 64'd1 : 64'd2);
    // Q_BP stall mid-packet on input 1
    do_reset();
    vt.delete(); gt.delete();
    t0 = cyc_n;
    for (int c = 0; c < 9; c++) begin
      Q_BP = c >= 4 && c < 8;
      f[1] = (c == 0) ? hdr(1, 4, 5) : pl(1, 4, 32'hB0 + 32'(c));
      D1_VALID = c < 6; D1 = f[1];
      if (c < 6) exp1.push_back(f[1]);
      tick();
    end
    drain(60);
    chk("t3_count", 64'(vt.size()), 64'd6);
    if (vt.size() == 6)
      for (int k = 0; k < 6; k++) chk("t3_time", 64'(vt[k]), 64'(t0 + ((k < 2) ? 3 + k : 7 + k)));
    // header-only packets alternate
    do_reset();
    vt.delete(); gt.delete();
    src_q = '{0, 1, 0, 1, 0, 1};
    for (int k = 0; k < 3; k++) drive(1, hdr(0, 5 + k, 0), 1, hdr(1, 5 + k, 0));
    drain(60);
    chk("t5_count", 64'(vt.size()), 64'd6);
    if (vt.size() == 6)
      for (int k = 1; k < 6; k++) chk("t5_gap", 64'(vt[k] - vt[k-1]), 64'd2);
    // backpressure threshold and overflow on input 0
    do_reset();
    Q_BP = 1'b1;
    for (int i = 0; i < 17; i++) begin
      f[0] = (i == 0) ? hdr(0, 9, 15) : pl(0, 9, 32'(i));
      D0_VALID = 1'b1; D0 = f[0];
      if (i < 16) exp0.push_back(f[0]);
      tick();
      chk("t4_bp", 64'(D0_BP), 64'(i + 1 >= 12));
      chk("t4_ovf", 64'(ERR_OVF), (i == 16) ? 64'd1 : 64'd0);
    end
    D0_VALID = 1'b0;
    tick();
    Q_BP = 1'b0;
    drain(100);
    chk("t4_ovf_sticky", 64'(ERR_OVF), 64'd1);
    chk("t4_bp_fall", 64'(D0_BP), 64'd0);
    // reset mid-packet, then a fresh packet on input 1
    vt.delete(); gt.delete();
    drive(1, hdr(0, 10, 7), 0, '0);
    for (int k = 1; k < 8; k++) drive(1, pl(0, 10, 32'hC0 + 32'(k)), 0, '0);
    D0_VALID = 1'b0;
    tick();
    chk("t6_pre_valid", 64'(Q_VALID), 64'd1);
    chk("t6_pre_grant", 64'(GRANT), 64'd1);
    SYS_RST_N = 1'b0;
    exp0.delete();
    #1;
    chk("t6_valid", 64'(Q_VALID), 64'd0);
    chk("t6_grant", 64'(GRANT), 64'd0);
    chk("t6_bp", 64'({D1_BP, D0_BP}), 64'd0);
    chk("t6_ovf", 64'(ERR_OVF), 64'd0);
    tick();
    SYS_RST_N = 1'b1;
    tick();
    vt.delete(); gt.delete();
    drive(0, '0, 1, hdr(1, 11, 2));
    drive(0, '0, 1, pl(1, 11, 32'hD1));
    drive(0, '0, 1, pl(1, 11, 32'hD2));
    drain(50);
    chk("t6_count", 64'(vt.size()), 64'd3);
    // randomized traffic respecting backpressure
    do_reset();
    rg = '{0, 0}; sq = '{100, 200};
    for (int c = 0; c < 700; c++) begin
      fin = c >= 500;
      if (fin && rg[0] == 0 && rg[1] == 0) break;
      Q_BP = !fin && ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 2; i++) begin
        v[i] = !((i == 0) ? D0_BP : D1_BP) && (fin ? rg[i] != 0 : $urandom_range(0, 3) != 0);
        f[i] = '0;
        if (v[i]) begin
          if (rg[i] == 0) begin
            n = int'($urandom_range(0, 5));
            f[i] = hdr(i, sq[i], n);
            rg[i] = n;
            sq[i]++;
          end else begin
            f[i] = pl(i, sq[i], $urandom());
            rg[i]--;
          end
        end
      end
      drive(v[0], f[0], v[1], f[1]);
    end
    Q_BP = 1'b0;
    drain(400);
    chk("rand_ovf", 64'(ERR_OVF), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
